// File: rtl/imux4_sel_ctrl.sv
// Round-robin select controller for one IMUX4 inverting 4:1 mux, with break-before-make select changes.
// Optional build macro IMUX4_SEL_CTRL_PARK_EN: float the selects whenever the controller goes idle.
module imux4_sel_ctrl #(
    parameter int HOLD_CYC = 4,
    parameter int DEAD_CYC = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] Req,
    output logic       Sel0,
    output logic       Sel0B,
    output logic       Sel1,
    output logic       Sel1B,
    output logic [3:0] Grant,
    output logic       Valid,
    inout  wire        VDD,
    inout  wire        VSS
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYC - 1);
    localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYC - 1);
    localparam logic [3:0] FLOAT     = 4'b0000;

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] sel_q, sel_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] idle_winner;
    logic [1:0] hold_winner;
    logic       others_req;

    // Select word layout is {Sel1, Sel1B, Sel0, Sel0B}
    function automatic logic [3:0] sel_code(input logic [1:0] ch);
        sel_code = {ch[1], ~ch[1], ch[0], ~ch[0]};
    endfunction

    function automatic logic [3:0] one_hot(input logic [1:0] ch);
        one_hot = 4'b0001 << ch;
    endfunction

    // Scan downward so the final overwrite is the nearest request after 'from'
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] from);
        logic [1:0] idx;
        rr_pick = from + 2'd1;
        for (int i = 4; i >= 1; i--) begin
            idx = from + 2'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    assign idle_winner = rr_pick(Req, last_q);
    assign hold_winner = rr_pick(Req, owner_q);
    assign others_req  = |(Req & ~one_hot(owner_q));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (|Req) begin
                    owner_d = idle_winner;
                    if (sel_q == FLOAT || sel_q == sel_code(idle_winner)) begin
                        state_d = HOLD;
                        last_d  = idle_winner;
                        cnt_d   = HOLD_LOAD;
                        sel_d   = sel_code(idle_winner);
                        grant_d = one_hot(idle_winner);
                    end else begin
                        state_d = BREAK;
                        cnt_d   = DEAD_LOAD;
                        sel_d   = FLOAT;
                        grant_d = 4'b0000;
                    end
                end
            end
            BREAK: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    last_d  = owner_q;
                    cnt_d   = HOLD_LOAD;
                    sel_d   = sel_code(owner_q);
                    grant_d = one_hot(owner_q);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (others_req) begin
                    state_d = BREAK;
                    owner_d = hold_winner;
                    cnt_d   = DEAD_LOAD;
                    sel_d   = FLOAT;
                    grant_d = 4'b0000;
                end else if (Req[owner_q]) begin
                    cnt_d = HOLD_LOAD;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    grant_d = 4'b0000;
`ifdef IMUX4_SEL_CTRL_PARK_EN
                    sel_d   = FLOAT;
`else
                    sel_d   = sel_q;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                sel_d   = FLOAT;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= 4'd0;
            sel_q   <= FLOAT;
            grant_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
        end
    end

    assign Sel1  = sel_q[3];
    assign Sel1B = sel_q[2];
    assign Sel0  = sel_q[1];
    assign Sel0B = sel_q[0];
    assign Grant = grant_q;
    // Derived only from registered selects, so it moves on the same edge as the code
    assign Valid = (Sel0 ^ Sel0B) && (Sel1 ^ Sel1B);

    logic unused_supply;
    assign unused_supply = VDD ^ VSS;

endmodule
